// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges load-use, branch, divider and data-memory stalls
// into per-stage write-enables/flushes. Optional stall counter under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lu_stall,
    input  logic        branch_taken,
    input  logic        div_start,
    input  logic        div_done,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        mem_wb_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        mem_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              div_pend, div_pend_nxt;
    logic              div_done_q, div_done_q_nxt;

    logic mem_stall;
    logic div_stall;
    logic mem_timeout;
    logic mem_exit;

    // Hazard classification for the current cycle
    always_comb begin
        mem_stall   = 1'b0;
        div_stall   = 1'b0;
        mem_timeout = 1'b0;
        mem_exit    = 1'b0;
        unique case (state)
            RUN: begin
                mem_stall = dmem_req & ~dmem_ack;
                div_stall = div_start & ~div_done;
            end
            DIV_WAIT: begin
                mem_stall = dmem_req & ~dmem_ack;
                div_stall = ~div_done;
            end
            MEM_WAIT: begin
                mem_stall   = ~dmem_ack & (wait_cnt < TIMEOUT_V);
                mem_timeout = ~dmem_ack & (wait_cnt == TIMEOUT_V);
                mem_exit    = dmem_ack | mem_timeout;
            end
            default: ;
        endcase
    end

    // Stage enables: first matching rule wins, reset forces bubbles everywhere
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        mem_err      = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            mem_err = mem_timeout;
            if (mem_stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                mem_wb_write = 1'b0;
                mem_wb_flush = 1'b1;
            end else if (div_stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_flush = 1'b1;
            end else if (branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu_stall) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Next-state and wait bookkeeping
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        div_pend_nxt   = div_pend;
        div_done_q_nxt = div_done_q;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WCNT_W'(1);
                    div_pend_nxt = div_start & ~div_done;
                end else if (div_stall) begin
                    state_nxt = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (mem_stall) begin
                    state_nxt      = MEM_WAIT;
                    wait_cnt_nxt   = WCNT_W'(1);
                    div_pend_nxt   = 1'b1;
                    // a completion coinciding with the memory stall must not be lost
                    div_done_q_nxt = div_done;
                end else if (div_done) begin
                    state_nxt = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_exit) begin
                    state_nxt      = (div_pend & ~div_done_q & ~div_done) ? DIV_WAIT : RUN;
                    wait_cnt_nxt   = '0;
                    div_pend_nxt   = 1'b0;
                    div_done_q_nxt = 1'b0;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCNT_W'(1);
                    if (div_done) begin
                        div_done_q_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            wait_cnt   <= '0;
            div_pend   <= 1'b0;
            div_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            div_pend   <= div_pend_nxt;
            div_done_q <= div_done_q_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Counts every cycle in which the front end is held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_write) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table-driven bench for pipe_ctrl (MEM_TIMEOUT=4), plus hand-written
// timeout and long-divide sequences.
module tb_pipe_ctrl;

    localparam int TO = 4;

    // expected action classes
    localparam int K_ADV = 0;
    localparam int K_MEM = 1;
    localparam int K_DIV = 2;
    localparam int K_BR  = 3;
    localparam int K_LU  = 4;
    localparam int K_RST = 5;
    localparam int K_TMO = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lu_stall = 1'b0, branch_taken = 1'b0, div_start = 1'b0, div_done = 1'b0;
    logic dmem_req = 1'b0, dmem_ack = 1'b0;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .lu_stall(lu_stall), .branch_taken(branch_taken),
        .div_start(div_start), .div_done(div_done),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .mem_err(mem_err)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic       rst_n, lu, br, ds, dd, req, ack;
        logic [4:0] w;    // {pc, if_id, id_ex, ex_mem, mem_wb} writes
        logic [3:0] f;    // {if_id, id_ex, ex_mem, mem_wb} flushes
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic lu, input logic br, input logic ds,
                       input logic dd, input logic req, input logic ack, input int kind);
        vec_t v;
        v.rst_n = r; v.lu = lu; v.br = br; v.ds = ds; v.dd = dd; v.req = req; v.ack = ack;
        v.err = 1'b0;
        case (kind)
            K_MEM:   begin v.w = 5'b00000; v.f = 4'b0001; end
            K_DIV:   begin v.w = 5'b00011; v.f = 4'b0010; end
            K_BR:    begin v.w = 5'b11111; v.f = 4'b1100; end
            K_LU:    begin v.w = 5'b00111; v.f = 4'b0100; end
            K_RST:   begin v.w = 5'b00000; v.f = 4'b1111; end
            K_TMO:   begin v.w = 5'b11111; v.f = 4'b0000; v.err = 1'b1; end
            default: begin v.w = 5'b11111; v.f = 4'b0000; end
        endcase
        vecs.push_back(v);
    endtask

    task automatic clear_inputs();
        lu_stall = 1'b0; branch_taken = 1'b0; div_start = 1'b0; div_done = 1'b0;
        dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    function automatic logic [4:0] writes();
        return {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write};
    endfunction

    function automatic logic [3:0] flushes();
        return {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    endfunction

    int stalls;
    int err_cycle;

    initial begin
        //   rst lu br ds dd req ack  action
        add(0, 0, 0, 0, 0, 0, 0, K_RST);
        add(0, 1, 1, 1, 0, 1, 0, K_RST);
        add(1, 0, 0, 0, 0, 0, 0, K_ADV);
        add(1, 1, 0, 0, 0, 0, 0, K_LU);
        add(1, 0, 0, 0, 0, 0, 0, K_ADV);
        add(1, 1, 1, 0, 0, 0, 0, K_BR);
        add(1, 0, 1, 0, 0, 0, 0, K_BR);
        add(1, 0, 0, 0, 0, 1, 1, K_ADV);   // zero-wait access
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);   // ack three cycles later
        add(1, 1, 1, 0, 0, 1, 0, K_MEM);
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);
        add(1, 0, 0, 0, 0, 1, 1, K_ADV);
        add(1, 0, 0, 0, 0, 0, 0, K_ADV);
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);   // never acked
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);
        add(1, 0, 0, 0, 0, 1, 0, K_TMO);
        add(1, 0, 0, 0, 0, 1, 1, K_ADV);
        add(1, 0, 0, 1, 0, 0, 0, K_DIV);   // divide N=2
        add(1, 0, 0, 0, 0, 0, 0, K_DIV);
        add(1, 0, 0, 0, 1, 0, 0, K_ADV);
        add(1, 1, 0, 0, 0, 0, 0, K_LU);
        add(1, 0, 0, 1, 1, 0, 0, K_ADV);   // start and done together
        add(1, 0, 0, 1, 0, 0, 0, K_DIV);   // div, mem stall, done inside MEM_WAIT
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);
        add(1, 0, 0, 0, 1, 1, 0, K_MEM);
        add(1, 0, 0, 0, 0, 1, 1, K_ADV);
        add(1, 1, 0, 0, 0, 0, 0, K_LU);    // back in RUN
        add(1, 0, 0, 1, 0, 0, 0, K_DIV);   // div still pending after mem exit
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);
        add(1, 0, 0, 0, 0, 1, 1, K_ADV);
        add(1, 0, 0, 0, 0, 0, 0, K_DIV);
        add(1, 0, 0, 0, 1, 0, 0, K_ADV);
        add(1, 0, 0, 1, 0, 1, 0, K_MEM);   // divide issued while memory stalls
        add(1, 0, 0, 0, 0, 1, 1, K_ADV);
        add(1, 0, 0, 0, 1, 0, 0, K_ADV);
        add(1, 0, 0, 1, 0, 0, 0, K_DIV);   // reset during DIV_WAIT
        add(1, 0, 0, 0, 0, 0, 0, K_DIV);
        add(0, 0, 0, 0, 0, 0, 0, K_RST);
        add(1, 0, 0, 0, 0, 0, 0, K_ADV);
        add(1, 1, 0, 0, 0, 0, 0, K_LU);
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);   // reset during MEM_WAIT
        add(0, 0, 0, 0, 0, 1, 0, K_RST);
        add(1, 0, 0, 0, 0, 0, 0, K_ADV);
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);
        add(1, 0, 0, 0, 0, 1, 0, K_MEM);
        add(1, 0, 0, 0, 0, 1, 0, K_TMO);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; lu_stall = vecs[i].lu; branch_taken = vecs[i].br;
            div_start = vecs[i].ds; div_done = vecs[i].dd;
            dmem_req = vecs[i].req; dmem_ack = vecs[i].ack;
            #1;
            check($sformatf("v%0d writes", i), 32'(writes()), 32'(vecs[i].w));
            check($sformatf("v%0d flushes", i), 32'(flushes()), 32'(vecs[i].f));
            check($sformatf("v%0d mem_err", i), 32'(mem_err), 32'(vecs[i].err));
`ifdef PIPE_CTRL_PERF_EN
            check($sformatf("v%0d stall_cnt", i), stall_cnt, 32'(exp_stall));
`endif
            if (!vecs[i].rst_n) exp_stall = 0;
            else if (!vecs[i].w[4]) exp_stall++;
        end

        // Memory never acks: count stall cycles until mem_err, bounded
        @(negedge clk);
        clear_inputs();
        dmem_req  = 1'b1;
        stalls    = 0;
        err_cycle = 0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (mem_err) begin
                err_cycle = c;
                check("tmo advance writes", 32'(writes()), 32'h1F);
                break;
            end
            if (!pc_write && mem_wb_flush) stalls++;
            @(negedge clk);
        end
        check("tmo stall cycles", 32'(stalls), 32'(TO));
        check("tmo err cycle", 32'(err_cycle), 32'(TO + 1));
        exp_stall += stalls;

        @(negedge clk);
        clear_inputs();
        lu_stall = 1'b1;
        #1;
        check("post-tmo load-use writes", 32'(writes()), 32'h07);
        exp_stall++;

        // Divide acked 5 cycles after start
        stalls = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            clear_inputs();
            div_start = (c == 1);
            div_done  = (c == 6);
            #1;
            if (c < 6 && !pc_write && ex_mem_flush) stalls++;
            if (c == 6) check("div5 advance writes", 32'(writes()), 32'h1F);
        end
        check("div5 stall cycles", 32'(stalls), 32'd5);
        exp_stall += stalls;

        @(negedge clk);
        clear_inputs();
        #1;
        check("idle writes", 32'(writes()), 32'h1F);
`ifdef PIPE_CTRL_PERF_EN
        check("final stall_cnt", stall_cnt, 32'(exp_stall));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencing controller for the 5-stage core. It merges four sources into one consistent set of per-stage register write-enables and flushes: the single-cycle load-use stall, the EX-stage branch redirect, the multi-cycle divider, and variable-latency data-memory waits. It sits between the hazard detection logic, the divider, the data-memory port and the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It also bounds memory waits with a timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 16, max stalled cycles per data-memory access (legal 1..255)

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- lu_stall  in  1  load-use hazard request
- branch_taken  in  1  taken branch/jump resolved in EX
- div_start  in  1  one-cycle pulse, divide issued from EX
- div_done  in  1  one-cycle pulse, quotient/remainder valid
- dmem_req  in  1  MEM-stage instruction accesses data memory
- dmem_ack  in  1  data memory completes the access this cycle
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  stage register update enable
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble into stage register
- mem_err  out  1  one-cycle pulse, memory access timed out
- stall_cnt  out  32  stall cycle counter (present only with PIPE_CTRL_PERF_EN)

## Operation
- States: RUN, DIV_WAIT, MEM_WAIT. Registers: state, wait_cnt ($clog2(MEM_TIMEOUT+1) bits), div_pend, div_done_q.
- The current cycle's action is selected by the first applicable rule, in this priority order. Outputs are combinational from state, registers and inputs. Unlisted writes are 1 and unlisted flushes are 0.
- MEM stall: (dmem_req & !dmem_ack) in RUN/DIV_WAIT, or MEM_WAIT with !dmem_ack and wait_cnt<MEM_TIMEOUT. Action: all *_write=0, mem_wb_flush=1.
- DIV stall: RUN with div_start & !div_done, or DIV_WAIT with !div_done. Action: pc_write=if_id_write=id_ex_write=0, ex_mem_flush=1.
- Branch: pc_write=1, if_id_flush=1, id_ex_flush=1.
- Load-use: pc_write=0, if_id_write=0, id_ex_flush=1.
- Otherwise advance: all writes=1, all flushes=0.
- Transitions:
  - RUN→MEM_WAIT on a MEM stall. Set wait_cnt=1 and div_pend = div_start & !div_done.
  - RUN→DIV_WAIT on a DIV stall.
  - DIV_WAIT→RUN on div_done.
  - DIV_WAIT→MEM_WAIT on a MEM stall. Set div_pend=1 and wait_cnt=1.
  - MEM_WAIT, no ack, wait_cnt<MEM_TIMEOUT: increment wait_cnt.
  - MEM_WAIT exit on dmem_ack or timeout. Timeout means wait_cnt==MEM_TIMEOUT with !dmem_ack; mem_err=1 that cycle and the pipeline advances. Next state is DIV_WAIT if div_pend & !div_done_q & !div_done, else RUN. Clear div_pend and div_done_q on exit.
- div_done during MEM_WAIT sets div_done_q.
- Simultaneous branch and load-use: branch wins, because the stalled ID instruction is flushed.
- Branch or load-use asserted during a MEM/DIV stall is ignored. Since EX/ID are frozen, the request re-presents when the stall ends.
- Zero-wait memory (dmem_req & dmem_ack in RUN): no stall.

## Timing
- Reset (rst_n=0 at clk edge): state=RUN, wait_cnt=0, div_pend=div_done_q=0, stall_cnt=0.
- While rst_n=0, outputs are forced: all *_write=0, all *_flush=1, mem_err=0.
- Reset mid-stall aborts the stall. The first cycle after release is in RUN.
- Zero-cycle latency: enables reflect inputs in the same cycle. State updates at the rising edge.
- Load-use: exactly 1 stall cycle.
- Memory never acking: the pipeline stalls exactly MEM_TIMEOUT cycles. It advances with mem_err=1 in cycle MEM_TIMEOUT+1 counted from the first dmem_req cycle.
- Divide acked N cycles after div_start: N stall cycles; advance in the div_done cycle.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt port and register exist.
  - Increments each non-reset cycle with pc_write=0.
  - Saturates at 32'hFFFF_FFFF.
- PIPE_CTRL_PERF_EN undefined: no stall_cnt port and no counter logic. All other behaviour is identical.

## Test plan
- lu_stall=1 for one cycle → pc_write=0, if_id_write=0, id_ex_flush=1 for that cycle only. stall_cnt +1.
- lu_stall=1 and branch_taken=1 together → pc_write=1, if_id_flush=1, id_ex_flush=1.
- dmem_req=1 with dmem_ack arriving 3 cycles later → 3 cycles all writes 0 with mem_wb_flush=1, advance on the ack cycle, mem_err=0.
- MEM_TIMEOUT=4, dmem_req held, no ack → 4 stall cycles, mem_err=1 in the 5th with all writes=1, then RUN.
- div_start, then dmem stall in DIV_WAIT, then div_done during MEM_WAIT, then dmem_ack → return to RUN (not DIV_WAIT), with no lost stall cycles.
- rst_n=0 asserted during DIV_WAIT → outputs forced to writes 0 / flushes 1. After release, state is RUN and writes=1.
